// File: rtl/fp_arb_pkg.sv
// Shared constants and the response tag type for the FP multiplier arbiter.
package fp_arb_pkg;

  localparam int N_REQ     = 4;
  localparam int SIG_WIDTH = 23;
  localparam int EXP_WIDTH = 8;
  localparam int FP_W      = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int FU_LAT    = 0;
  localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // One tag per FP-unit pipeline stage: which requester owns the result.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  logic             w_found;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one external FP multiplier among N_REQ requesters; a tag pipeline
// tracks result ownership so responses return in accept order.
module fp_mult_arbiter #(
  parameter int N_REQ       = fp_arb_pkg::N_REQ,
  parameter int SIG_WIDTH   = fp_arb_pkg::SIG_WIDTH,
  parameter int EXP_WIDTH   = fp_arb_pkg::EXP_WIDTH,
  parameter int FU_LAT      = fp_arb_pkg::FU_LAT,
  localparam int FP_W       = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  input  logic [N_REQ*3-1:0]    req_rnd,
  output logic                  fu_valid,
  output logic [FP_W-1:0]       fu_a,
  output logic [FP_W-1:0]       fu_b,
  output logic [2:0]            fu_rnd,
  input  logic [FP_W-1:0]       fu_z,
  input  logic [7:0]            fu_status,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]       rsp_z,
  output logic [7:0]            rsp_status,
  output logic [2:0]            inflight
);

  import fp_arb_pkg::*;

  logic [IDX_W-1:0] r_ptr;
  tag_t             r_tag [0:FU_LAT];
  logic [FP_W-1:0]  r_fu_a;
  logic [FP_W-1:0]  r_fu_b;
  logic [2:0]       r_fu_rnd;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [FP_W-1:0]  r_rsp_z;
  logic [7:0]       r_rsp_status;
  logic [2:0]       r_inflight;

  logic [N_REQ-1:0] w_grant;
  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_next_ptr;
  logic [FP_W-1:0]  w_sel_a;
  logic [FP_W-1:0]  w_sel_b;
  logic [2:0]       w_sel_rnd;
  logic [N_REQ-1:0] w_rsp_onehot;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign req_ready = rst_n ? w_grant : '0;
  assign w_accept  = |req_ready;

  always_comb begin
    w_idx     = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_rnd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_idx     = IDX_W'(i);
        w_sel_a   = req_a[i*FP_W +: FP_W];
        w_sel_b   = req_b[i*FP_W +: FP_W];
        w_sel_rnd = req_rnd[i*3 +: 3];
      end
    end
    w_next_ptr = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + IDX_W'(1);
  end

  // The last tag stage lines up with fu_z; its owner gets the strobe.
  always_comb begin
    w_rsp_onehot                    = '0;
    w_rsp_onehot[r_tag[FU_LAT].idx] = r_tag[FU_LAT].valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      for (int k = 0; k <= FU_LAT; k++) r_tag[k] <= '0;
      r_fu_a       <= '0;
      r_fu_b       <= '0;
      r_fu_rnd     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_z      <= '0;
      r_rsp_status <= '0;
      r_inflight   <= '0;
    end else begin
      r_tag[0] <= '{valid: w_accept, idx: w_idx};
      for (int k = 1; k <= FU_LAT; k++) r_tag[k] <= r_tag[k-1];
      if (w_accept) begin
        r_ptr    <= w_next_ptr;
        r_fu_a   <= w_sel_a;
        r_fu_b   <= w_sel_b;
        r_fu_rnd <= w_sel_rnd;
      end
      r_rsp_valid <= w_rsp_onehot;
      if (r_tag[FU_LAT].valid) begin
        r_rsp_z      <= fu_z;
        r_rsp_status <= fu_status;
      end
      // An operation stays counted until the cycle its rsp_valid is visible.
      unique case ({w_accept, |r_rsp_valid})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign fu_valid   = r_tag[0].valid;
  assign fu_a       = r_fu_a;
  assign fu_b       = r_fu_b;
  assign fu_rnd     = r_fu_rnd;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_z      = r_rsp_z;
  assign rsp_status = r_rsp_status;
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench: two arbiters (FU_LAT=0 and FU_LAT=2) share stimulus, each
// driving its own behavioural single-precision multiplier model.
module tb_fp_mult_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   reqValid;
  logic [NR*W-1:0] reqA;
  logic [NR*W-1:0] reqB;
  logic [NR*3-1:0] reqRnd;

  logic [NR-1:0] ready0, rspValid0, ready2, rspValid2;
  logic          fuValid0, fuValid2;
  logic [W-1:0]  fuA0, fuB0, fuZ0, rspZ0, fuA2, fuB2, fuZ2, rspZ2;
  logic [2:0]    fuRnd0, fuRnd2, inflight0, inflight2;
  logic [7:0]    fuStatus0, rspStatus0, fuStatus2, rspStatus2;

  int nApplied = 0;
  int nMiss    = 0;

  fp_mult_arbiter #(.N_REQ(NR), .SIG_WIDTH(23), .EXP_WIDTH(8), .FU_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(ready0),
    .req_a(reqA), .req_b(reqB), .req_rnd(reqRnd),
    .fu_valid(fuValid0), .fu_a(fuA0), .fu_b(fuB0), .fu_rnd(fuRnd0),
    .fu_z(fuZ0), .fu_status(fuStatus0),
    .rsp_valid(rspValid0), .rsp_z(rspZ0), .rsp_status(rspStatus0),
    .inflight(inflight0)
  );

  fp_mult_arbiter #(.N_REQ(NR), .SIG_WIDTH(23), .EXP_WIDTH(8), .FU_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(ready2),
    .req_a(reqA), .req_b(reqB), .req_rnd(reqRnd),
    .fu_valid(fuValid2), .fu_a(fuA2), .fu_b(fuB2), .fu_rnd(fuRnd2),
    .fu_z(fuZ2), .fu_status(fuStatus2),
    .rsp_valid(rspValid2), .rsp_z(rspZ2), .rsp_status(rspStatus2),
    .inflight(inflight2)
  );

  // Truncating multiplier; status bits: 0 zero, 1 infinity, 2 invalid, 5 inexact.
  function automatic logic [39:0] fpMul(input logic [31:0] a, input logic [31:0] b);
    logic        s, nanA, nanB, infA, infB, zeroA, zeroB;
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] frac;
    logic        inexact;
    s     = a[31] ^ b[31];
    nanA  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nanB  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    infA  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    infB  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    zeroA = (a[30:23] == 8'h00);
    zeroB = (b[30:23] == 8'h00);
    if (nanA || nanB || (infA && zeroB) || (zeroA && infB))
      return {8'h04, 32'h7FC00000};
    if (infA || infB)
      return {8'h02, s, 8'hFF, 23'h0};
    if (zeroA || zeroB)
      return {8'h01, s, 31'h0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      frac    = m[46:24];
      inexact = (m[23:0] != 0);
      e       = e + 10'd1;
    end else begin
      frac    = m[45:23];
      inexact = (m[22:0] != 0);
    end
    return {(inexact ? 8'h20 : 8'h00), s, e[7:0], frac};
  endfunction

  always_comb {fuStatus0, fuZ0} = fpMul(fuA0, fuB0);

  logic [39:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= fpMul(fuA2, fuB2);
    pipe2 <= pipe1;
  end
  assign {fuStatus2, fuZ2} = pipe2;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic [31:0] expZ;
    logic [7:0]  expSt;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    reqValid = valid;
  endtask

  task automatic setSlot(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd);
    reqA[i*W +: W]   = a;
    reqB[i*W +: W]   = b;
    reqRnd[i*3 +: 3] = rnd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int peak0, peak2, clampDec;
    logic [3:0] oneHot;

    vecs[0] = '{2, 32'h3F800000, 32'h40000000, 3'd0, 32'h40000000, 8'h00};
    vecs[1] = '{0, 32'h3FC00000, 32'h3FC00000, 3'd1, 32'h40100000, 8'h00};
    vecs[2] = '{1, 32'hBFC00000, 32'h40000000, 3'd2, 32'hC0400000, 8'h00};
    vecs[3] = '{3, 32'h7F800000, 32'h00000000, 3'd3, 32'h7FC00000, 8'h04};
    vecs[4] = '{2, 32'h7F800000, 32'h40000000, 3'd4, 32'h7F800000, 8'h02};
    vecs[5] = '{1, 32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800002, 8'h20};
    vecs[6] = '{0, 32'h40400000, 32'h3F000000, 3'd6, 32'h3FC00000, 8'h00};

    reqValid = '0;
    reqA     = {NR{32'hDEADBEEF}};
    reqB     = {NR{32'hDEADBEEF}};
    reqRnd   = '0;
    rst_n    = 1'b0;
    tick();
    tick();

    // Reset state, with requests pending to show ready is held off.
    applyStimulus(4'hF);
    settle();
    checkOutput("rst_ready0", 32'(ready0), 0);
    checkOutput("rst_ready2", 32'(ready2), 0);
    checkOutput("rst_fu_valid", 32'(fuValid0), 0);
    checkOutput("rst_rsp_valid", 32'(rspValid2), 0);
    checkOutput("rst_inflight", 32'(inflight0), 0);
    checkOutput("rst_fu_a", fuA0, 0);
    checkOutput("rst_rsp_z", rspZ2, 0);
    tick();
    applyStimulus(4'h0);
    rst_n = 1'b1;
    tick();

    // All four valid for 8 cycles: strict rotation, responses in order.
    for (int i = 0; i < NR; i++) setSlot(i, 32'h3F800000, 32'h3F800000 + (i << 23), 3'(i));
    for (int k = 0; k < 12; k++) begin
      applyStimulus(k < 8 ? 4'hF : 4'h0);
      settle();
      checkOutput("rr_ready", 32'(ready0), k < 8 ? (1 << (k % 4)) : 0);
      if (k >= 2 && k < 10) begin
        checkOutput("rr_rsp0_valid", 32'(rspValid0), 1 << ((k - 2) % 4));
        checkOutput("rr_rsp0_z", rspZ0, 32'h3F800000 + (((k - 2) % 4) << 23));
      end
      if (k >= 4) begin
        checkOutput("rr_rsp2_valid", 32'(rspValid2), 1 << ((k - 4) % 4));
        checkOutput("rr_rsp2_z", rspZ2, 32'h3F800000 + (((k - 4) % 4) << 23));
      end
      clampDec = (k - 2 < 0) ? 0 : (k - 2 > 8) ? 8 : k - 2;
      checkOutput("rr_inflight0", 32'(inflight0), ((k < 8) ? k : 8) - clampDec);
      clampDec = (k - 4 < 0) ? 0 : (k - 4 > 8) ? 8 : k - 4;
      checkOutput("rr_inflight2", 32'(inflight2), ((k < 8) ? k : 8) - clampDec);
      tick();
    end

    // Single operations through both latencies, other slots hold junk.
    for (int v = 0; v < 7; v++) begin
      reqA   = {NR{32'hDEADBEEF}};
      reqB   = {NR{32'hDEADBEEF}};
      reqRnd = '1;
      setSlot(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].rnd);
      oneHot = 4'(1 << vecs[v].idx);
      applyStimulus(oneHot);
      settle();
      checkOutput("vec_ready", 32'(ready0), 32'(oneHot));
      tick();
      applyStimulus(4'h0);
      settle();
      checkOutput("vec_fu_valid", 32'(fuValid0), 1);
      checkOutput("vec_fu_a", fuA0, vecs[v].a);
      checkOutput("vec_fu_b", fuB0, vecs[v].b);
      checkOutput("vec_fu_rnd", 32'(fuRnd0), 32'(vecs[v].rnd));
      checkOutput("vec_inflight0", 32'(inflight0), 1);
      tick();
      settle();
      checkOutput("vec_fu_idle", 32'(fuValid0), 0);
      checkOutput("vec_rsp0_valid", 32'(rspValid0), 32'(oneHot));
      checkOutput("vec_rsp0_z", rspZ0, vecs[v].expZ);
      checkOutput("vec_rsp0_status", 32'(rspStatus0), 32'(vecs[v].expSt));
      checkOutput("vec_rsp2_early", 32'(rspValid2), 0);
      tick();
      settle();
      checkOutput("vec_rsp0_once", 32'(rspValid0), 0);
      checkOutput("vec_rsp0_hold", rspZ0, vecs[v].expZ);
      checkOutput("vec_inflight0_done", 32'(inflight0), 0);
      tick();
      settle();
      checkOutput("vec_rsp2_valid", 32'(rspValid2), 32'(oneHot));
      checkOutput("vec_rsp2_z", rspZ2, vecs[v].expZ);
      checkOutput("vec_rsp2_status", 32'(rspStatus2), 32'(vecs[v].expSt));
      tick();
      settle();
      checkOutput("vec_inflight2_done", 32'(inflight2), 0);
      tick();
    end

    // Requester 3 alone for five cycles: back-to-back accepts and responses.
    setSlot(3, 32'h3F800000, 32'h40400000, 3'd0);
    peak0 = 0;
    peak2 = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(k < 5 ? 4'h8 : 4'h0);
      settle();
      if (k < 5) checkOutput("lone3_ready", 32'(ready0), 8);
      checkOutput("lone3_rsp0", 32'(rspValid0), (k >= 2 && k <= 6) ? 8 : 0);
      checkOutput("lone3_rsp2", 32'(rspValid2), (k >= 4 && k <= 8) ? 8 : 0);
      if (int'(inflight0) > peak0) peak0 = int'(inflight0);
      if (int'(inflight2) > peak2) peak2 = int'(inflight2);
      tick();
    end
    checkOutput("lone3_peak0", 32'(peak0), 2);
    checkOutput("lone3_peak2", 32'(peak2), 4);

    // Pointer wrap: park ptr at 3, then requesters 1 and 3 compete.
    applyStimulus(4'b0100);
    tick();
    applyStimulus(4'b1010);
    settle();
    checkOutput("wrap_first", 32'(ready0), 32'b1000);
    tick();
    settle();
    checkOutput("wrap_second", 32'(ready0), 32'b0010);
    tick();
    applyStimulus(4'b1011);
    settle();
    checkOutput("wrap_ptr2", 32'(ready2), 32'b1000);
    tick();
    applyStimulus(4'h0);
    for (int k = 0; k < 6; k++) tick();

    // One-cycle reset with two operations in flight.
    applyStimulus(4'b0010);
    tick();
    applyStimulus(4'b0100);
    tick();
    applyStimulus(4'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      checkOutput("flush_rsp0", 32'(rspValid0), 0);
      checkOutput("flush_rsp2", 32'(rspValid2), 0);
      checkOutput("flush_inflight0", 32'(inflight0), 0);
      checkOutput("flush_inflight2", 32'(inflight2), 0);
      tick();
    end
    applyStimulus(4'b1100);
    settle();
    checkOutput("flush_ptr0_dut0", 32'(ready0), 32'b0100);
    checkOutput("flush_ptr0_dut2", 32'(ready2), 32'b0100);
    tick();
    applyStimulus(4'h0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule

// File: doc/fp_mult_arbiter.md
FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the FP unit.
REQ-002 Parameter SIG_WIDTH, default 23: significand width; EXP_WIDTH, default 8: exponent width; FP_W = SIG_WIDTH+EXP_WIDTH+1.
REQ-003 Parameter FU_LAT, default 0: cycles from fu_valid to fu_z/fu_status being valid; 0 means a combinational DW_fp_mult, legal range 0..4.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  N_REQ  per-requester operation request.
REQ-007 req_ready  output  N_REQ  per-requester grant; at most one bit high.
REQ-008 req_a, req_b  input  N_REQ*FP_W  per-requester operands; requester i in slice [i*FP_W +: FP_W].
REQ-009 req_rnd  input  N_REQ*3  per-requester rounding mode.
REQ-010 fu_valid  output  1  issue strobe to the shared FP unit.
REQ-011 fu_a, fu_b  output  FP_W  registered operands to the FP unit; fu_rnd  output  3  registered rounding mode.
REQ-012 fu_z  input  FP_W  FP unit result; fu_status  input  8  FP unit status.
REQ-013 rsp_valid  output  N_REQ  one-hot response strobe to the owning requester.
REQ-014 rsp_z  output  FP_W  shared response result bus; rsp_status  output  8  shared response status bus.
REQ-015 inflight  output  3  count of accepted operations not yet responded.

Function
REQ-016 Handshake: an operation is accepted in cycle t when req_valid[i] and req_ready[i] are both high; requester holds operands stable while req_valid is high and unaccepted.
REQ-017 Arbitration: round-robin; grant goes to the first valid requester at or after pointer ptr, searching upward modulo N_REQ.
REQ-018 ptr advances to (grantee+1) mod N_REQ after each accept; ptr is unchanged in cycles with no accept.
REQ-019 One accept per cycle maximum; no stall exists, so a lone valid requester is accepted every cycle.
REQ-020 req_ready is combinational from req_valid and ptr; req_ready is all-zero when req_valid is all-zero.
REQ-021 Issue: accept at t gives fu_valid=1 with the granted operands and rnd on fu_a/fu_b/fu_rnd at t+1; fu_valid=0 otherwise, and fu_a/fu_b/fu_rnd hold their last values.
REQ-022 Tag pipeline: the grantee index travels FU_LAT+1 stages alongside the FP unit; fu_z and fu_status are sampled at t+1+FU_LAT.
REQ-023 Response: rsp_valid[grantee], rsp_z and rsp_status are registered at t+2+FU_LAT; the total latency is FU_LAT+2 cycles, exactly one cycle high.
REQ-024 Responses emerge in accept order; requesters cannot backpressure responses.
REQ-025 rsp_z and rsp_status hold their last values when rsp_valid is all-zero.
REQ-026 inflight increments on accept and decrements on response; when both occur in the same cycle it is unchanged; its maximum is FU_LAT+2.
REQ-027 fu_status bits pass through to rsp_status unmodified; the arbiter does not interpret NaN, Inf or exception bits.

Reset
REQ-028 While rst_n=0 at a clock edge: ptr=0, all tag stages invalid, inflight=0, fu_valid=0, rsp_valid=0, and fu_a, fu_b, fu_rnd, rsp_z, rsp_status all 0.
REQ-029 req_ready is forced all-zero while rst_n=0.
REQ-030 Reset mid-operation discards all in-flight operations; no rsp_valid is produced for them after reset release.

Structure
REQ-031 A shared package fp_arb_pkg holds N_REQ, SIG_WIDTH, EXP_WIDTH, FP_W, FU_LAT and the tag type (index of width clog2(N_REQ) plus a valid bit).
REQ-032 One sub-module rr_arbiter (request vector plus pointer in, one-hot grant out) is instantiated; the FP unit itself is external to this block.

Verification
REQ-033 Bench models the FP unit as DW_fp_mult with FU_LAT=0 and also as a registered FU_LAT=2 version; both are run.
REQ-034 Scenario: requester 2 alone, a=0x3F800000, b=0x40000000, rnd=0, accepted at t -> rsp_valid=4'b0100 and rsp_z=0x40000000 at t+2 (FU_LAT=0).
REQ-035 Scenario: all four valid for 8 cycles from reset -> grants in order 0,1,2,3,0,1,2,3 and responses in the same order.
REQ-036 Scenario: requester 3 alone for 5 consecutive cycles -> accepted every cycle, 5 responses back-to-back, inflight peaks at 2 (FU_LAT=0) or 4 (FU_LAT=2).
REQ-037 Scenario: ptr=3 with requesters 1 and 3 valid -> grant 3 first, then 1 (wrap-around), then ptr=2.
REQ-038 Scenario: rst_n low for 1 cycle with 2 operations in flight -> no rsp_valid afterwards, inflight=0, and the next grant is taken from ptr=0.
REQ-039 Scenario: a=0x7F800000 (Inf), b=0x00000000 -> rsp_status equals the bench model's fu_status bit-for-bit, including the invalid flag.
